// File: rtl/line_packer_pkg.sv
// Shared constants and state encoding for the line packer.
package line_packer_pkg;

  localparam logic [15:0] HDR_MAGIC_DEF  = 16'hA5A5;
  localparam logic [15:0] TRL_MAGIC      = 16'h5A5A;
  localparam int          WORDS_PER_BEAT = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_HEADER = 3'd1;
  localparam state_t ST_PACK   = 3'd2;
  localparam state_t ST_PAD    = 3'd3;
  localparam state_t ST_DROP   = 3'd4;

endpackage

// File: rtl/lp_pix_pair.sv
// Packs pairs of 16-bit pixels into 32-bit words; a final odd pixel is
// flushed alone with the upper half zeroed. word_vld is a one-cycle pulse.
module lp_pix_pair
  import line_packer_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        clr,
  input  logic        pix_vld,
  input  logic        pix_last,
  input  logic [15:0] pix_data,
  output logic [31:0] word,
  output logic        word_vld
);

  logic        half_q, half_d;
  logic [15:0] low_q, low_d;
  logic [31:0] word_q, word_d;
  logic        vld_q, vld_d;

  always_comb begin
    half_d = half_q;
    low_d  = low_q;
    word_d = word_q;
    vld_d  = 1'b0;
    if (clr) begin
      half_d = 1'b0;
      low_d  = '0;
    end else if (pix_vld) begin
      if (half_q) begin
        word_d = {pix_data, low_q};
        vld_d  = 1'b1;
        half_d = 1'b0;
      end else if (pix_last) begin
        word_d = {16'h0000, pix_data};
        vld_d  = 1'b1;
      end else begin
        low_d  = pix_data;
        half_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      half_q <= 1'b0;
      low_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      half_q <= half_d;
      low_q  <= low_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word     = word_q;
  assign word_vld = vld_q;

endmodule

// File: rtl/line_packer.sv
// Packs 16-bit scanner pixels into 32-bit FIFO words with a per-line header,
// 4-word alignment padding and line dropping. LINE_PACKER_TRAILER_EN adds a checksum trailer.
module line_packer
  import line_packer_pkg::*;
#(
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF,
  parameter logic [11:0] AFULL_THR = 12'd3584,
  parameter logic [11:0] OVF_THR   = 12'd4092
) (
  input  logic        CLK,
  input  logic        SRST,
  input  logic        ENABLE,
  input  logic [15:0] LINE_LEN,
  input  logic        LINE_START,
  input  logic [15:0] PIX_DATA,
  input  logic        PIX_DV,
  input  logic [11:0] WR_CNT,
  output logic [31:0] FIFO_DIN,
  output logic        FIFO_DIN_DV,
  output logic [15:0] LINE_CNT,
  output logic [15:0] DROP_CNT,
  output logic        OVF,
  output logic        BUSY,
  output state_t      dbg_state
);

  // Write interface: FIFO_DIN_DV is a one-cycle strobe per word with no
  // backpressure; FIFO_DIN is meaningful only while DV is high and holds otherwise.

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [1:0]  word_cnt_q, word_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        ovf_q, ovf_d;
  logic [31:0] fifo_din_q, fifo_din_d;
  logic        fifo_dv_q, fifo_dv_d;

  logic        wr;
  logic [31:0] wr_data;
  logic        pix_take;
  logic        pix_last;
  logic [31:0] pair_word;
  logic        pair_vld;
  logic        trl_pend;
  logic [31:0] trl_word;

  // Pixels count only while a line is open and until LINE_LEN is reached.
  assign pix_take = PIX_DV && (pix_cnt_q != len_q) &&
                    ((state_q == ST_HEADER) || (state_q == ST_PACK) || (state_q == ST_DROP));
  assign pix_last = (pix_cnt_q + 16'd1) == len_q;

  lp_pix_pair u_pair (
    .clk      (CLK),
    .srst     (SRST),
    .clr      (state_q == ST_IDLE),
    .pix_vld  (pix_take && (state_q != ST_DROP)),
    .pix_last (pix_last),
    .pix_data (PIX_DATA),
    .word     (pair_word),
    .word_vld (pair_vld)
  );

`ifdef LINE_PACKER_TRAILER_EN
  logic [15:0] sum_q, sum_d;
  logic        trl_pend_q, trl_pend_d;
  logic        trl_wr;

  assign trl_wr = (state_q == ST_PAD) && trl_pend_q;

  always_comb begin
    sum_d      = sum_q;
    trl_pend_d = trl_pend_q;
    if (state_q == ST_IDLE) begin
      sum_d      = '0;
      trl_pend_d = 1'b1;
    end else begin
      if (pix_take) sum_d = sum_q + PIX_DATA;
      if (trl_wr) trl_pend_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      sum_q      <= '0;
      trl_pend_q <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      trl_pend_q <= trl_pend_d;
    end
  end

  assign trl_pend = trl_pend_q;
  assign trl_word = {TRL_MAGIC, sum_q};
`else
  assign trl_pend = 1'b0;
  assign trl_word = '0;
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pix_cnt_d  = pix_cnt_q;
    word_cnt_d = word_cnt_q;
    line_cnt_d = line_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    fifo_din_d = fifo_din_q;
    wr         = 1'b0;
    wr_data    = '0;

    case (state_q)
      ST_IDLE: begin
        pix_cnt_d  = '0;
        word_cnt_d = '0;
        if (LINE_START && ENABLE) begin
          len_d = LINE_LEN;
          if (WR_CNT > AFULL_THR) begin
            state_d = ST_DROP;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            state_d = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        wr         = 1'b1;
        wr_data    = {HDR_MAGIC, line_cnt_q};
        line_cnt_d = line_cnt_q + 16'd1;
        state_d    = (len_q == 16'd0) ? ST_PAD : ST_PACK;
      end
      ST_PACK: begin
        if (pair_vld) begin
          wr      = 1'b1;
          wr_data = pair_word;
          // The last word of the line is the one emitted once every pixel is in.
          if (pix_cnt_q == len_q) state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        if (trl_pend) begin
          wr      = 1'b1;
          wr_data = trl_word;
        end else if (word_cnt_q != 2'd0) begin
          wr      = 1'b1;
          wr_data = 32'h0;
        end
        if (!wr || (word_cnt_q == 2'(WORDS_PER_BEAT - 1))) state_d = ST_IDLE;
      end
      ST_DROP: begin
        if ((len_q == 16'd0) || (pix_take && pix_last)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (pix_take) pix_cnt_d = pix_cnt_q + 16'd1;
    if (wr) begin
      word_cnt_d = word_cnt_q + 2'd1;
      fifo_din_d = wr_data;
      if (WR_CNT >= OVF_THR) ovf_d = 1'b1;
    end
    fifo_dv_d = wr;
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      pix_cnt_q  <= '0;
      word_cnt_q <= '0;
      line_cnt_q <= '0;
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
      fifo_din_q <= '0;
      fifo_dv_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pix_cnt_q  <= pix_cnt_d;
      word_cnt_q <= word_cnt_d;
      line_cnt_q <= line_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
      fifo_din_q <= fifo_din_d;
      fifo_dv_q  <= fifo_dv_d;
    end
  end

  assign FIFO_DIN    = fifo_din_q;
  assign FIFO_DIN_DV = fifo_dv_q;
  assign LINE_CNT    = line_cnt_q;
  assign DROP_CNT    = drop_cnt_q;
  assign OVF         = ovf_q;
  assign BUSY        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule
